// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared pixel type and pooling FSM state encoding
package cnn_pkg;

  localparam int unsigned PIX_W = 32;

  typedef logic signed [PIX_W-1:0] pixel_t;

  // TOP collects horizontal pair maxima of even rows, BOT finishes each 2x2 window.
  typedef enum logic {
    ST_TOP = 1'b0,
    ST_BOT = 1'b1
  } pool_state_t;

endpackage

// File: rtl/pool_linebuf.sv
// rtl/pool_linebuf.sv - one-write one-read line buffer with combinational read
module pool_linebuf #(
  parameter int DEPTH  = 13,
  parameter int DATA_W = 32,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Always written by the even row before the odd row reads it, so no reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/relu_maxpool.sv
// rtl/relu_maxpool.sv - streaming 2x2 stride-2 max pooling with ReLU
module relu_maxpool
  import cnn_pkg::*;
#(
  parameter int FMAP_WIDTH  = 26,
  parameter int FMAP_HEIGHT = 26,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_pool,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err_last
);

  localparam int CW       = (FMAP_WIDTH > 1) ? $clog2(FMAP_WIDTH) : 1;
  localparam int RW       = (FMAP_HEIGHT > 1) ? $clog2(FMAP_HEIGHT) : 1;
  localparam int LB_DEPTH = FMAP_WIDTH / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef logic signed [DATA_W-1:0] pix_t;

  function automatic pix_t smax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  pool_state_t     state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  pix_t            hreg_q, hreg_d;
  logic            out_valid_q, out_valid_d;
  pix_t            out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic            err_last_q, err_last_d;

  logic            accept;
  logic            col_end;
  logic            row_end;
  logic            map_end;
  logic            lb_wr_en;
  logic [AW-1:0]   lb_addr;
  logic [DATA_W-1:0] lb_rd_data;
  pix_t            pair_max;
  pix_t            win_max;

  assign in_ready = !out_valid_q || out_ready;

  pool_linebuf #(
    .DEPTH  (LB_DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_linebuf (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (pair_max),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  always_comb begin
    accept   = in_valid && in_ready;
    col_end  = (col_q == CW'(FMAP_WIDTH - 1));
    row_end  = (row_q == RW'(FMAP_HEIGHT - 1));
    map_end  = col_end && row_end;
    lb_addr  = AW'(col_q >> 1);
    pair_max = smax(hreg_q, in_data);
    // Folding in zero here is the single ReLU; the output can never go negative.
    win_max  = smax(smax(pair_max, lb_rd_data), '0);
    lb_wr_en = accept && (state_q == ST_TOP) && col_q[0];

    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hreg_d      = hreg_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_last_d  = err_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (!col_q[0]) begin
        hreg_d = in_data;
      end

      if (col_end) begin
        col_d   = '0;
        row_d   = row_end ? '0 : row_q + 1'b1;
        state_d = (state_q == ST_TOP) ? ST_BOT : ST_TOP;
      end else begin
        col_d = col_q + 1'b1;
      end

      // A reload here may coincide with the drain above; the reload wins, giving no bubble.
      if ((state_q == ST_BOT) && col_q[0]) begin
        out_valid_d = 1'b1;
        out_data_d  = win_max;
        out_last_d  = map_end;
      end

      if (in_last != map_end) begin
        err_last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_pool) begin
    if (!rst_pool) begin
      state_q     <= ST_TOP;
      col_q       <= '0;
      row_q       <= '0;
      hreg_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hreg_q      <= hreg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_last_q  <= err_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err_last  = err_last_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb/tb_relu_maxpool.sv - scoreboard bench for relu_maxpool on a 4x4 map
module tb_relu_maxpool;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 32;
  localparam int NP = W * H;

  logic          clk = 1'b0;
  logic          rst_pool = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic          err_last;
  logic [DW-1:0] out_data;

  int total = 0;
  int bad = 0;
  int stall_cycles = 0;
  bit rand_ready = 1'b0;
  bit rand_valid = 1'b0;

  logic [DW:0]          exp_q[$];
  logic [DW:0]          mon_e;
  logic signed [DW-1:0] pix [NP];

  relu_maxpool #(
    .FMAP_WIDTH  (W),
    .FMAP_HEIGHT (H),
    .DATA_W      (DW)
  ) dut (
    .clk       (clk),
    .rst_pool  (rst_pool),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err_last  (err_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  always @(negedge clk) begin
    if (rst_pool && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0d expected none", $signed(out_data));
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e[DW-1:0]);
        check("out_last", DW'(out_last), DW'(mon_e[DW]));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_exp(input logic signed [DW-1:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic push_ramp_exp();
    push_exp(5, 1'b0);
    push_exp(7, 1'b0);
    push_exp(13, 1'b0);
    push_exp(15, 1'b1);
  endtask

  task automatic model_push();
    logic signed [DW-1:0] m;
    for (int r = 0; r < H; r += 2) begin
      for (int c = 0; c < W; c += 2) begin
        m = 0;
        if (pix[r*W+c] > m)       m = pix[r*W+c];
        if (pix[r*W+c+1] > m)     m = pix[r*W+c+1];
        if (pix[(r+1)*W+c] > m)   m = pix[(r+1)*W+c];
        if (pix[(r+1)*W+c+1] > m) m = pix[(r+1)*W+c+1];
        push_exp(m, (r == H - 2) && (c == W - 2));
      end
    end
  endtask

  // Called and returns at posedge+1; transfer is decided by in_ready at the preceding negedge.
  task automatic send(input logic signed [DW-1:0] d, input logic last);
    int n;
    n = 0;
    if (rand_valid) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      stall_cycles++;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_map(input int last_idx, input int count);
    for (int i = 0; i < count; i++) send(pix[i], i == last_idx);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NP; i++) pix[i] = i;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d outputs missing expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_pool = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", DW'(out_valid), 0);
    check("rst_in_ready", DW'(in_ready), 1);
    check("rst_err_last", DW'(err_last), 0);
    rst_pool = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", DW'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", DW'(out_last), 0);
    check("rst_err_last", DW'(err_last), 0);
    check("rst_in_ready", DW'(in_ready), 1);
    rst_pool = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Ramp, twice back-to-back with a free consumer: no input stall allowed.
    load_ramp();
    stall_cycles = 0;
    push_ramp_exp();
    push_ramp_exp();
    send_map(NP - 1, NP);
    send_map(NP - 1, NP);
    drain();
    check("b2b_stalls", stall_cycles, 0);
    check("ramp_err_last", DW'(err_last), 0);

    for (int i = 0; i < NP; i++) pix[i] = -7;
    for (int i = 0; i < 4; i++) push_exp(0, i == 3);
    send_map(NP - 1, NP);
    drain();

    for (int i = 0; i < NP; i++) pix[i] = -100;
    pix[0] = -3;
    pix[1] = 9;
    pix[4] = 12;
    pix[5] = -1;
    push_exp(12, 1'b0);
    push_exp(0, 1'b0);
    push_exp(0, 1'b0);
    push_exp(0, 1'b1);
    send_map(NP - 1, NP);
    drain();

    load_ramp();
    out_ready = 1'b0;
    push_ramp_exp();
    fork
      send_map(NP - 1, NP);
      begin
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("stall_seen_valid", DW'(out_valid), 1);
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", DW'(in_ready), 0);
          check("stall_out_valid", DW'(out_valid), 1);
          check("stall_out_data", out_data, 5);
          check("stall_out_last", DW'(out_last), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    push_ramp_exp();
    send_map(10, NP);
    drain();
    check("err_set", DW'(err_last), 1);
    push_ramp_exp();
    send_map(NP - 1, NP);
    drain();
    check("err_sticky", DW'(err_last), 1);
    do_reset();
    check("err_after_reset", DW'(err_last), 0);

    // Partial map: window 0 completes at pixel 5 and is emitted before the reset.
    push_exp(5, 1'b0);
    send_map(NP - 1, 7);
    drain();
    do_reset();
    push_ramp_exp();
    send_map(NP - 1, NP);
    drain();
    check("post_reset_err", DW'(err_last), 0);

    rand_valid = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < NP; i++) pix[i] = $signed($urandom_range(0, 200)) - 100;
    model_push();
    send_map(NP - 1, NP);
    for (int i = 0; i < NP; i++) pix[i] = $signed($urandom_range(0, 200)) - 100;
    model_push();
    send_map(NP - 1, NP);
    drain();
    rand_valid = 1'b0;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("final_out_valid", DW'(out_valid), 0);
    check("final_err_last", DW'(err_last), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/relu_maxpool.md
RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 Parameter FMAP_WIDTH, default 26: input feature-map columns; SHALL be even and at least 2.
REQ-002 Parameter FMAP_HEIGHT, default 26: input feature-map rows; SHALL be even and at least 2.
REQ-003 Parameter DATA_W, default 32: pixel width, two's-complement signed.
REQ-004 Port list SHALL be:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_pool, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: in_data is valid this cycle.
- in_ready, output, 1: block accepts in_data this cycle.
- in_data, input, DATA_W: convolution output pixel, raster order (row-major).
- in_last, input, 1: marks the final pixel of a map.
- out_valid, output, 1: out_data is valid this cycle.
- out_ready, input, 1: consumer accepts out_data this cycle.
- out_data, output, DATA_W: pooled, rectified pixel.
- out_last, output, 1: marks the final pooled pixel of a map.
- err_last, output, 1: sticky flag for in_last misalignment.

Function
REQ-005 Input transfer SHALL occur iff in_valid && in_ready; output transfer SHALL occur iff out_valid && out_ready.
REQ-006 Each transferred pixel SHALL advance col (0..FMAP_WIDTH-1) and row (0..FMAP_HEIGHT-1); col wraps to 0 and increments row; (H-1, W-1) wraps both to 0.
REQ-007 The FSM SHALL have states TOP (even row) and BOT (odd row); TOP->BOT on accepting col W-1 of an even row; BOT->TOP on accepting col W-1 of an odd row.
REQ-008 In TOP, even col: hold pixel in hreg; odd col: write max(hreg, pixel) into line buffer entry col/2 (FMAP_WIDTH/2 entries x DATA_W).
REQ-009 In BOT, even col: hold pixel in hreg; odd col: load output register with max(hreg, pixel, linebuf[col/2], 0) and set out_valid the next cycle (latency 1 cycle from the bottom-right pixel).
REQ-010 All comparisons SHALL be signed; ReLU (clamp negatives to 0) SHALL be applied exactly once, so out_data >= 0 always; no width growth.
REQ-011 in_ready SHALL be !out_valid || out_ready (single output register, combinational pass-through ready); in_ready SHALL never depend on in_valid.
REQ-012 out_valid, out_data, out_last SHALL stay stable while out_valid && !out_ready.
REQ-013 Simultaneous output transfer and a new bottom-right input SHALL reload the output register in the same cycle with no bubble.
REQ-014 out_last SHALL be 1 only on the pooled pixel from input (H-1, W-1); each map yields exactly (W/2)*(H/2) outputs.
REQ-015 err_last SHALL set when in_last is transferred with (row, col) != (H-1, W-1), or when (H-1, W-1) is transferred with in_last=0; it clears only on reset; data flow SHALL be unaffected.
REQ-016 Back-to-back maps SHALL stream with no idle cycle between them.

Reset
REQ-017 While rst_pool=0: state=TOP, row=col=0, hreg=0, out_valid=0, out_data=0, out_last=0, err_last=0, in_ready=1.
REQ-018 Line buffer contents SHALL not require reset; it is always written in TOP before being read in BOT.
REQ-019 Reset asserted mid-map SHALL discard the partial map; the first pixel after deassertion is (0,0).

Structure
REQ-020 A shared package cnn_pkg SHALL hold the pixel typedef (signed DATA_W) and the pool FSM state enum.
REQ-021 The line buffer SHALL be a separate sub-module pool_linebuf: one write port, one read port, combinational read, depth FMAP_WIDTH/2.

Verification
REQ-022 Directed tests (W=H=4 unless noted):
- Ramp 0..15 with out_ready=1 -> outputs 5, 7, 13, 15; out_last on 15 only; err_last=0.
- All pixels -7 -> four outputs of 0.
- Top pair {-3, 9}, bottom pair {12, -1} in one window -> output 12.
- Hold out_ready=0 for 5 cycles when first output valid -> in_ready=0, data held stable; after release, remaining outputs correct and none lost.
- in_last on pixel 10 -> err_last=1 and stays 1; outputs unchanged; a reset clears it.
- rst_pool pulsed after pixel 6, then a full ramp 0..15 -> outputs 5, 7, 13, 15 only.
- Two maps back-to-back with random in_valid/out_ready -> eight outputs matching the reference model.
